dw_shad_reg_bank: RTL and testbench

Parameterised bank of num_regs system registers, each width bits wide, with a paired shadow scan chain.
- Capture: the shadow chain snapshots all system registers in one cycle.
- Read-out: the chain is shifted out serially, either manually (SE) or by an internal dump engine that runs for exactly width*num_regs cycles.
- Update: the shadow contents can be written back into the system registers for debug override.
The block sits in the debug/observability path next to datapath control registers, on a single clock.

---
 rtl/dw_shad_reg_bank_if.sv | 36 +++
 rtl/dw_shad_reg_bank.sv | 130 +++++++++++++
 tb/tb_dw_shad_reg_bank.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/dw_shad_reg_bank_if.sv
// ---------------------------------------------------------------------------
// dw_shad_reg_bank_if
//   Bundles the data/control signals of dw_shad_reg_bank. sys_clk and reset
//   stay plain ports on the bank itself.
//
//   master (driver side) drives : datain, load, capture, SE, SI, update,
//                                 dump_start
//   slave  (register bank) drives: sys_out, shad_out, SO, busy, done
// ---------------------------------------------------------------------------
interface dw_shad_reg_bank_if #(
    parameter int width    = 8,
    parameter int num_regs = 4
) ();
    logic [width*num_regs-1:0] datain;      // parallel load data, slice k = [k*width +: width]
    logic [num_regs-1:0]       load;        // per-register load enable
    logic                      capture;     // snapshot system regs into shadow chain
    logic                      SE;          // manual shift enable
    logic                      SI;          // serial input into chain bit 0
    logic                      update;      // copy shadow chain into system regs
    logic                      dump_start;  // start automatic serial dump
    logic [width*num_regs-1:0] sys_out;     // system register contents
    logic [width*num_regs-1:0] shad_out;    // shadow chain contents
    logic                      SO;          // serial out (chain MSB)
    logic                      busy;        // dump engine shifting
    logic                      done;        // one-cycle dump-complete pulse

    modport master (
        output datain, load, capture, SE, SI, update, dump_start,
        input  sys_out, shad_out, SO, busy, done
    );

    modport slave (
        input  datain, load, capture, SE, SI, update, dump_start,
        output sys_out, shad_out, SO, busy, done
    );
endinterface

// File: rtl/dw_shad_reg_bank.sv
// ---------------------------------------------------------------------------
// dw_shad_reg_bank
//   Bank of num_regs system registers (width bits each) with a paired shadow
//   scan chain for debug observability and override.
//     - capture : whole bank snapshotted into the chain in one cycle
//     - SE / SI : manual serial shift, MSB (reg num_regs-1, bit width-1) first
//     - dump    : internal engine shifts the full chain out in exactly
//                 width*num_regs cycles, then pulses done
//     - update  : chain written back into the system registers
//   With bld_shad_reg == 0 the chain and dump engine are not built; the
//   system registers still work.
//
//   Ports:
//     sys_clk : clock, all state on rising edge
//     reset   : synchronous, active-low
//     bus     : dw_shad_reg_bank_if.slave (data/control bundle)
// ---------------------------------------------------------------------------
module dw_shad_reg_bank #(
    parameter int width        = 8,
    parameter int num_regs     = 4,
    parameter bit bld_shad_reg = 1'b1
) (
    input  logic                   sys_clk,
    input  logic                   reset,
    dw_shad_reg_bank_if.slave      bus
);
    localparam int n     = width * num_regs;
    localparam int cnt_w = (n > 1) ? $clog2(n) : 1;

    logic [n-1:0] sys_q;
    logic [n-1:0] shad_q;
    logic         busy_q;
    logic         done_q;
    logic         do_update;

    // Update is locked out while the dump engine owns the chain.
    assign do_update = bus.update && !busy_q && bld_shad_reg;

    // System registers: update beats per-register load, otherwise hold.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; capture below relies on reading sys_q before this
    // edge's load/update.
    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            sys_q <= '0;
        end else begin
            for (int k = 0; k < num_regs; k++) begin
                if (do_update)
                    sys_q[k*width +: width] <= shad_q[k*width +: width];
                else if (bus.load[k])
                    sys_q[k*width +: width] <= bus.datain[k*width +: width];
            end
        end
    end

    generate
        if (bld_shad_reg) begin : g_shad
            typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

            state_t             state_q;
            logic [cnt_w-1:0]   cnt_q;
            logic [n-1:0]       shift_val;

            // Dropping the concatenation MSB gives {shad[n-2:0], SI}, and
            // degenerates to just SI when n == 1.
            assign shift_val = n'({shad_q, bus.SI});

            always_ff @(posedge sys_clk) begin
                if (!reset)
                    shad_q <= '0;
                else if (busy_q)
                    shad_q <= shift_val;
                else if (bus.capture)
                    shad_q <= sys_q;
                else if (bus.SE)
                    shad_q <= shift_val;
            end

            // Dump engine: busy/done are registered alongside the state so
            // busy is high for exactly the n SHIFT cycles.
            always_ff @(posedge sys_clk) begin
                if (!reset) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end else begin
                    case (state_q)
                        IDLE: begin
                            done_q <= 1'b0;
                            if (bus.dump_start) begin
                                state_q <= SHIFT;
                                cnt_q   <= cnt_w'(n - 1);
                                busy_q  <= 1'b1;
                            end
                        end
                        SHIFT: begin
                            if (cnt_q == '0) begin
                                state_q <= DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q - cnt_w'(1);
                            end
                        end
                        DONE: begin
                            state_q <= IDLE;
                            done_q  <= 1'b0;
                        end
                        default: begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b0;
                        end
                    endcase
                end
            end
        end else begin : g_no_shad
            assign shad_q = '0;
            assign busy_q = 1'b0;
            assign done_q = 1'b0;
        end
    endgenerate

    assign bus.sys_out  = sys_q;
    assign bus.shad_out = shad_q;
    assign bus.SO       = shad_q[n-1];
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_dw_shad_reg_bank.sv
// ---------------------------------------------------------------------------
// tb_dw_shad_reg_bank
//   Directed bench for dw_shad_reg_bank (width=8, num_regs=4). One instance
//   with the shadow chain built, one with it tied off; both share sys_clk and
//   reset. Load behaviour is table-driven; capture/shift, dump, interference,
//   update override and reset-abort are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_dw_shad_reg_bank;
    localparam int W  = 8;
    localparam int NR = 4;
    localparam int N  = W * NR;

    logic sys_clk = 1'b0;
    logic reset;

    always #5 sys_clk = ~sys_clk;

    dw_shad_reg_bank_if #(.width(W), .num_regs(NR)) bus  ();
    dw_shad_reg_bank_if #(.width(W), .num_regs(NR)) bus0 ();

    dw_shad_reg_bank #(.width(W), .num_regs(NR), .bld_shad_reg(1'b1)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus)
    );

    dw_shad_reg_bank #(.width(W), .num_regs(NR), .bld_shad_reg(1'b0)) dut0 (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus0)
    );

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [NR-1:0] load;
        logic [N-1:0]  datain;
        logic [N-1:0]  exp_sys;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.datain = '0; bus.load = '0; bus.capture = 0; bus.SE = 0;
        bus.SI = 0; bus.update = 0; bus.dump_start = 0;
    endtask

    // Load pat, capture it, dump it; optionally poke every control mid-dump.
    task automatic run_dump(input logic [N-1:0] pat, input bit interfere);
        int busy_cycles;
        bus.load = '1; bus.datain = pat;
        tick();
        bus.load = '0; bus.datain = '0;
        bus.capture = 1;
        tick();
        bus.capture = 0;
        bus.dump_start = 1;
        tick();
        bus.dump_start = 0;
        busy_cycles = 0;
        for (int j = 0; j < N; j++) begin
            check("dump_so", N'(bus.SO), N'(pat[N-1-j]));
            if (bus.busy) busy_cycles++;
            if (bus.done) check("dump_early_done", N'(bus.done), '0);
            if (interfere) begin
                bus.dump_start = (j == 5);
                bus.capture    = (j == 6);
                bus.SE         = (j == 7);
                bus.update     = (j == 8);
            end
            tick();
        end
        idle_inputs();
        check("dump_busy_cycles", N'(busy_cycles), N'(N));
        check("dump_busy_at_done", N'(bus.busy), '0);
        check("dump_done_pulse", N'(bus.done), N'(1));
        check("dump_shad_drained", bus.shad_out, '0);
        check("dump_sys_kept", bus.sys_out, pat);
        tick();
        check("dump_done_one_cycle", N'(bus.done), '0);
        check("dump_no_restart", N'(bus.busy), '0);
    endtask

    initial begin
        logic [N-1:0] pat;
        bit           flag;

        vecs[0] = '{load: 4'b0101, datain: 32'hDDCCBBAA, exp_sys: 32'h00CC00AA};
        vecs[1] = '{load: 4'b1010, datain: 32'h44332211, exp_sys: 32'h44CC22AA};
        vecs[2] = '{load: 4'b0000, datain: 32'hFFFFFFFF, exp_sys: 32'h44CC22AA};
        vecs[3] = '{load: 4'b1111, datain: 32'h80000001, exp_sys: 32'h80000001};

        idle_inputs();
        bus0.datain = '0; bus0.load = '0; bus0.capture = 0; bus0.SE = 0;
        bus0.SI = 0; bus0.update = 0; bus0.dump_start = 0;

        // Reset held low for two cycles.
        reset = 1'b0;
        tick();
        tick();
        check("rst_sys", bus.sys_out, '0);
        check("rst_shad", bus.shad_out, '0);
        check("rst_so", N'(bus.SO), '0);
        check("rst_busy", N'(bus.busy), '0);
        check("rst_done", N'(bus.done), '0);
        reset = 1'b1;

        // Table-driven loads.
        foreach (vecs[i]) begin
            bus.load = vecs[i].load;
            bus.datain = vecs[i].datain;
            tick();
            check("load_sys", bus.sys_out, vecs[i].exp_sys);
            check("load_shad", bus.shad_out, '0);
            check("load_busy", N'(bus.busy), '0);
        end
        idle_inputs();

        // Capture then manual shift of 80000001: SO = 1, 0 x30, 1.
        pat = 32'h80000001;
        bus.capture = 1;
        tick();
        bus.capture = 0;
        check("cap_shad", bus.shad_out, pat);
        bus.SE = 1;
        bus.SI = 0;
        for (int j = 0; j < N; j++) begin
            check("man_so", N'(bus.SO), N'(pat[N-1-j]));
            tick();
        end
        bus.SE = 0;
        check("man_shad_empty", bus.shad_out, '0);

        // Automatic dump, clean and with interference.
        run_dump(32'hA5A50F0F, 1'b0);
        run_dump(32'hA5A50F0F, 1'b1);

        // Update override: shift 12345678 in MSB-first, then update beats load.
        pat = 32'h12345678;
        bus.SE = 1;
        for (int j = 0; j < N; j++) begin
            bus.SI = pat[N-1-j];
            tick();
        end
        bus.SE = 0;
        bus.SI = 0;
        check("shift_in_shad", bus.shad_out, pat);
        bus.update = 1;
        bus.load = '1;
        bus.datain = '0;
        tick();
        idle_inputs();
        check("update_wins", bus.sys_out, pat);

        // Reset at SHIFT cycle 10 aborts the dump without done.
        bus.dump_start = 1;
        tick();
        bus.dump_start = 0;
        repeat (10) tick();
        check("mid_dump_busy", N'(bus.busy), N'(1));
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort_busy", N'(bus.busy), '0);
        check("abort_done", N'(bus.done), '0);
        check("abort_shad", bus.shad_out, '0);
        flag = 0;
        repeat (40) begin
            tick();
            if (bus.done || bus.busy) flag = 1;
        end
        check("abort_no_done_later", N'(flag), '0);

        // Shadow chain not built: only the system registers react.
        bus0.load = '1;
        bus0.datain = 32'hCAFEF00D;
        tick();
        bus0.load = '0;
        check("nobld_sys", bus0.sys_out, 32'hCAFEF00D);
        bus0.capture = 1; bus0.SE = 1; bus0.SI = 1; bus0.update = 1; bus0.dump_start = 1;
        flag = 0;
        repeat (40) begin
            tick();
            bus0.capture = 0; bus0.update = 0; bus0.dump_start = 0;
            if (bus0.busy || bus0.done || bus0.SO || (bus0.shad_out != '0)) flag = 1;
        end
        check("nobld_quiet", N'(flag), '0);
        check("nobld_sys_kept", bus0.sys_out, 32'hCAFEF00D);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
